shared_reg_arbiter: RTL
=======================

# shared_reg_arbiter

Two-requester arbiter and write sequencer for a shared WIDTH-bit storage register built from the team's positive-edge D flip-flops with asynchronous active-low reset. It accepts write requests from two clients over a req/gnt handshake and grants at most one client per cycle. It loads the granted client's data into the shared register and exposes the register contents plus a write counter. It sits between the two producer blocks and the register bank, and is the only writer of that bank.

## Interface
- WIDTH, 4, data width of the shared register (1..16)
- C  input  1  clock, all state changes on rising edge
- RE  input  1  reset, asynchronous, active-low
- req0  input  1  write request from client 0, level
- req1  input  1  write request from client 1, level
- d0  input  WIDTH  write data from client 0, valid while gnt0 high
- d1  input  WIDTH  write data from client 1, valid while gnt1 high
- gnt0  output  1  grant to client 0, one cycle per accepted request
- gnt1  output  1  grant to client 1, one cycle per accepted request
- Q  output  WIDTH  shared register contents
- Qnot  output  WIDTH  bitwise complement of Q
- wr_cnt  output  8  count of completed writes, wraps

## Operation
- State register st ∈ {IDLE, G0, G1}; last-winner bit lw (0 = client 0 served last, 1 = client 1 served last).
- Moore outputs: gnt0 = (st==G0), gnt1 = (st==G1); never both high.
- Rising edge with st==G0: Q <= d0, wr_cnt <= wr_cnt+1, lw <= 0. With st==G1: Q <= d1, wr_cnt <= wr_cnt+1, lw <= 1.
- Effective requests per cycle: e0 = req0 & (st!=G0), e1 = req1 & (st!=G1). A client's own req is masked in its grant cycle.
- Next state on each rising edge:
  - e0 & !e1 -> G0; e1 & !e0 -> G1; neither -> IDLE.
  - e0 & e1 -> G0 if lw==1, else G1 (round-robin, see Configuration).
- Client protocol: hold req until gnt is observed. Drop req in the cycle after gnt unless another write is wanted. A req still high one cycle after its gnt is a new request.
- wr_cnt wraps 255 -> 0 with no flag.
- Q and Qnot always complementary, including in reset.

## Timing
- Reset (RE low, asynchronous, immediate): st=IDLE, gnt0=gnt1=0, Q=0, Qnot=all ones, wr_cnt=0, lw=1.
- RE low mid-grant: gnt drops immediately and that write is lost; wr_cnt is not incremented.
- First rising edge after RE deasserts is a normal arbitration edge.
- Latency:
  - req sampled high at edge k -> gnt high from edge k to edge k+1 -> Q updated at edge k+1.
  - Request to data visible on Q: 2 edges.
- Back-to-back: grants can alternate G0, G1, G0, … every cycle with no IDLE gap. Throughput is one write per cycle.
- Simultaneous first requests after reset: client 0 wins (lw reset to 1).
- d0/d1 sampled only at the edge ending the grant cycle; other cycles are don't-care.

## Configuration
- RR_EN defined: tie-break uses lw as above (round-robin).
- RR_EN undefined: on e0 & e1, client 0 always wins. lw is still maintained but does not affect arbitration.
- Reset values, handshake and latency are identical in both builds.

## Test plan
- Reset: RE=0 with req0=req1=1 and C toggling -> gnt0=gnt1=0, Q=0000, Qnot=1111, wr_cnt=0 throughout.
- Single write: req0=1 for one edge with d0=1010 -> gnt0 high exactly one cycle, Q=1010 and Qnot=0101 one edge later, wr_cnt=1.
- Contention: req0=req1=1 held continuously, d0=0011, d1=1100, RR_EN defined -> gnt sequence G0, G1, G0, G1; Q alternates 0011, 1100; wr_cnt=4 after 4 grants. Same stimulus without RR_EN -> the per-cycle self-mask still alternates G0, G1 each cycle.
- Tie after client 0 served: with RR_EN, after a G0 grant let both requests rise together -> G1 granted first. Without RR_EN -> G0 granted first.
- Async reset mid-grant: drive RE low in the middle of the gnt1 cycle with d1=1111 and Q=0101 -> gnt1 falls immediately, Q=0000, wr_cnt=0, no write of 1111.
- Counter wrap: 256 back-to-back single-client writes -> wr_cnt reads 255 after the 255th and 0 after the 256th; Q holds the last written data.

Source files
------------

// File: rtl/shared_reg_arbiter.sv
// Two-client round-robin/fixed-priority arbiter that sequences writes into one shared register.
// Build option: define RR_EN for round-robin tie-break; otherwise client 0 wins ties.
//
// state | meaning
// IDLE  | no grant outstanding
// G0    | client 0 granted, d0 captured on the edge ending this cycle
// G1    | client 1 granted, d1 captured on the edge ending this cycle
module shared_reg_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             C,
  input  logic             RE,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qnot,
  output logic [7:0]       wr_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t st;
  logic   lw;
  logic   e0;
  logic   e1;
  logic   tie0;

  // A client's own request is ignored during its grant cycle, so a held req alternates.
  assign e0 = req0 & (st != G0);
  assign e1 = req1 & (st != G1);

`ifdef RR_EN
  assign tie0 = lw;
`else
  // lw is still tracked but fixed priority always favours client 0.
  assign tie0 = 1'b1 | lw;
`endif

  always_ff @(posedge C or negedge RE) begin
    if (!RE) begin
      st     <= IDLE;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      Q      <= '0;
      wr_cnt <= 8'd0;
      lw     <= 1'b1;
    end else begin
      case (st)
        G0: begin
          Q      <= d0;
          wr_cnt <= wr_cnt + 8'd1;
          lw     <= 1'b0;
        end
        G1: begin
          Q      <= d1;
          wr_cnt <= wr_cnt + 8'd1;
          lw     <= 1'b1;
        end
        default: ;
      endcase

      if (e0 && (!e1 || tie0)) begin
        st   <= G0;
        gnt0 <= 1'b1;
        gnt1 <= 1'b0;
      end else if (e1) begin
        st   <= G1;
        gnt0 <= 1'b0;
        gnt1 <= 1'b1;
      end else begin
        st   <= IDLE;
        gnt0 <= 1'b0;
        gnt1 <= 1'b0;
      end
    end
  end

  assign Qnot = ~Q;

endmodule
